// File: rtl/hid_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package hid_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } hid_state_e;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;
    localparam int         ENTRY_W    = 10;

endpackage

// File: rtl/hid_sync_filter.sv
// Synchronises the PS/2 pins, debounces the clock line and strobes on each
// filtered falling edge.
module hid_sync_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic dspclk,
    input  logic reset,
    input  logic hid_clk,
    input  logic hid_dat,
    output logic fall_stb,
    output logic dat_sync
);

    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       filt_q, filt_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fall_q, fall_d;

    // The filtered level flips on the FILT_LEN-th consecutive cycle of disagreement.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == 8'(FILT_LEN - 1)) begin
                filt_d = clk_sync_q[1];
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge dspclk) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            filt_q     <= 1'b1;
            cnt_q      <= '0;
            fall_q     <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], hid_clk};
            dat_sync_q <= {dat_sync_q[0], hid_dat};
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            fall_q     <= fall_d;
        end
    end

    assign fall_stb = fall_q;
    assign dat_sync = dat_sync_q[1];

endmodule

// File: rtl/hid_rx_fifo.sv
// PS/2 keyboard receiver: deframes and parity-checks scan codes, folds E0/F0
// prefixes into flags, and queues decoded codes in a valid/ready FIFO.
module hid_rx_fifo
    import hid_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_US  = 2000,
    parameter int FIFO_DEPTH  = 8,
    parameter bit ODD_PARITY  = 1'b1
) (
    input  logic       dspclk,
    input  logic       reset,
    input  logic       hid_clk,
    input  logic       hid_dat,
    output logic       code_valid,
    input  logic       code_ready,
    output logic [7:0] code_data,
    output logic       code_brk,
    output logic       code_ext,
    output logic       pari_err,
    output logic       frame_err,
    output logic       overflow,
    output logic [7:0] led
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          TMO_CYC  = CLK_FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    logic fall_stb;
    logic dat_sync;

    hid_sync_filter #(
        .FILT_LEN (FILT_LEN)
    ) u_sync (
        .dspclk   (dspclk),
        .reset    (reset),
        .hid_clk  (hid_clk),
        .hid_dat  (hid_dat),
        .fall_stb (fall_stb),
        .dat_sync (dat_sync)
    );

    hid_state_e  state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [31:0] tmo_q, tmo_d;
    logic        good_q, good_d;
    logic        pari_q, pari_d;
    logic        ferr_q, ferr_d;
    logic        abort;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = tmo_q;
        good_d  = 1'b0;
        pari_d  = 1'b0;
        ferr_d  = 1'b0;
        abort   = 1'b0;
        if (state_q != IDLE) tmo_d = tmo_q + 32'd1;
        if (fall_stb) begin
            tmo_d = '0;
            unique case (state_q)
                IDLE: begin
                    if (!dat_sync) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d = {dat_sync, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat_sync;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!dat_sync)                              ferr_d = 1'b1;
                    else if ((^shift_q ^ par_q) != ODD_PARITY) pari_d = 1'b1;
                    else                                        good_d = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == 32'(TMO_CYC - 1)) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
            abort   = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge dspclk) begin
        if (!reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            tmo_q   <= '0;
            good_q  <= 1'b0;
            pari_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tmo_q   <= tmo_d;
            good_q  <= good_d;
            pari_q  <= pari_d;
            ferr_q  <= ferr_d;
        end
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    // Prefix folding runs the cycle after the stop edge; shift_q still holds the byte.
    logic ext_q, ext_d;
    logic brk_q, brk_d;
    logic push;

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (pari_d || abort) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (good_q) begin
            if (shift_q == PREFIX_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PREFIX_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, rd_q;
    logic [AW:0]        cnt_q, cnt_d;
    logic               ovf_q;
    logic [7:0]         led_q;
    logic               full, pop, accept;
    logic [ENTRY_W-1:0] head;

    assign code_valid = (cnt_q != '0);
    assign full       = (cnt_q == CNT_FULL);
    assign pop        = code_valid && code_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign accept     = push && (!full || pop);

    always_comb begin
        cnt_d = cnt_q;
        if (accept && !pop)      cnt_d = cnt_q + (AW + 1)'(1);
        else if (!accept && pop) cnt_d = cnt_q - (AW + 1)'(1);
    end

    always_ff @(posedge dspclk) begin
        if (!reset) begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            led_q <= 8'h00;
        end else begin
            ext_q <= ext_d;
            brk_q <= brk_d;
            cnt_q <= cnt_d;
            ovf_q <= push && !accept;
            if (accept) wr_q <= wr_q + AW'(1);
            if (pop)    rd_q <= rd_q + AW'(1);
            if (push && !brk_q) led_q <= shift_q;
        end
    end

    always_ff @(posedge dspclk) begin
        if (accept) mem_q[wr_q] <= {ext_q, brk_q, shift_q};
    end

    assign head      = mem_q[rd_q];
    assign code_data = code_valid ? head[7:0] : 8'h00;
    assign code_brk  = code_valid ? head[8]   : 1'b0;
    assign code_ext  = code_valid ? head[9]   : 1'b0;
    assign pari_err  = pari_q;
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;
    assign led       = led_q;

endmodule

// File: tb/tb_hid_rx_fifo.sv
// Randomised bench for hid_rx_fifo: drives PS/2 frames and checks pops, pulses
// and led against a queue-based model of the decoded key stream.
module tb_hid_rx_fifo;

    localparam int DEPTH = 8;
    localparam int HB    = 20;
    localparam int GAP   = 40;

    logic       dspclk = 1'b0;
    logic       reset;
    logic       hid_clk;
    logic       hid_dat;
    logic       code_valid;
    logic       code_ready;
    logic [7:0] code_data;
    logic       code_brk;
    logic       code_ext;
    logic       pari_err;
    logic       frame_err;
    logic       overflow;
    logic [7:0] led;

    hid_rx_fifo #(
        .CLK_FREQ_HZ (1000000),
        .FILT_LEN    (4),
        .TIMEOUT_US  (200),
        .FIFO_DEPTH  (DEPTH),
        .ODD_PARITY  (1'b1)
    ) dut (
        .dspclk     (dspclk),
        .reset      (reset),
        .hid_clk    (hid_clk),
        .hid_dat    (hid_dat),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_data  (code_data),
        .code_brk   (code_brk),
        .code_ext   (code_ext),
        .pari_err   (pari_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .led        (led)
    );

    always #5 dspclk = ~dspclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge dspclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents and pending prefix flags.
    logic [9:0] mq[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] exp_led = 8'h00;
    int         exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
    int         perr_seen = 0, ferr_seen = 0, ovf_seen = 0;
    logic [7:0] prev_led = 8'h00;
    int         led_cyc = 0;
    int         stop_cyc = 0;
    int         push_lat = 0;
    logic       hold_prev = 1'b0;
    logic [9:0] head_prev = '0;

    always @(negedge dspclk) begin
        #1;
        if (code_valid && code_ready) begin
            if (mq.size() == 0) begin
                chk("pop_unexpected", 32'(code_valid), 32'd0);
            end else begin
                chk("pop_entry", 32'({code_ext, code_brk, code_data}), 32'(mq.pop_front()));
            end
        end
        if (hold_prev && code_valid)
            chk("head_stable", 32'({code_ext, code_brk, code_data}), 32'(head_prev));
        hold_prev = code_valid && !code_ready;
        head_prev = {code_ext, code_brk, code_data};
        if (pari_err || frame_err || overflow)
            chk("pulse_onehot", 32'(pari_err) + 32'(frame_err) + 32'(overflow), 32'd1);
        perr_seen += int'(pari_err);
        ferr_seen += int'(frame_err);
        ovf_seen  += int'(overflow);
        if (led !== prev_led) begin
            prev_led = led;
            led_cyc  = cyc;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge dspclk);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                               input bit pop_at_push);
        if (bad_stop) begin
            exp_ferr++;
        end else if (bad_par) begin
            exp_perr++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (!m_brk) exp_led = b;
            if (mq.size() >= DEPTH && !code_ready && !pop_at_push) exp_ovf++;
            else mq.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit glitch, input bit pop_at_push);
        logic [10:0] bits;
        logic        p;
        p = ~(^b);
        if (bad_par) p = ~p;
        bits = {~bad_stop, p, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            hid_dat = bits[i];
            if (glitch && i == 4) begin
                wait_cyc(5);
                hid_clk = 1'b0;
                wait_cyc(3);
                hid_clk = 1'b1;
                wait_cyc(HB - 8);
            end else begin
                wait_cyc(HB);
            end
            hid_clk = 1'b0;
            if (i == 10) begin
                stop_cyc = cyc;
                model_frame(b, bad_par, bad_stop, pop_at_push);
                for (int k = 0; k < HB; k++) begin
                    if (pop_at_push) code_ready = (cyc == stop_cyc + push_lat - 1);
                    wait_cyc(1);
                end
                if (pop_at_push) code_ready = 1'b0;
            end else begin
                wait_cyc(HB);
            end
            hid_clk = 1'b1;
        end
        hid_dat = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i <= nbits; i++) begin
            hid_dat = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            wait_cyc(HB);
            hid_clk = 1'b0;
            wait_cyc(HB);
            hid_clk = 1'b1;
        end
        hid_dat = 1'b1;
    endtask

    task automatic send_bad_start();
        hid_dat = 1'b1;
        wait_cyc(HB);
        hid_clk = 1'b0;
        exp_ferr++;
        wait_cyc(HB);
        hid_clk = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic checkpoint(input string tag);
        chk({tag, "_perr"}, 32'(perr_seen), 32'(exp_perr));
        chk({tag, "_ferr"}, 32'(ferr_seen), 32'(exp_ferr));
        chk({tag, "_ovf"},  32'(ovf_seen),  32'(exp_ovf));
        chk({tag, "_led"},  32'(led),       32'(exp_led));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         r;
        logic [7:0] b;
        reset      = 1'b0;
        hid_clk    = 1'b1;
        hid_dat    = 1'b1;
        code_ready = 1'b1;
        wait_cyc(5);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_data",  32'({code_ext, code_brk, code_data}), 32'd0);
        chk("rst_led",   32'(led), 32'd0);
        chk("rst_pulses", 32'({pari_err, frame_err, overflow}), 32'd0);
        reset = 1'b1;
        wait_cyc(20);

        send_frame(8'h1C, 0, 0, 0, 0);
        checkpoint("make");
        push_lat = led_cyc - stop_cyc;
        chk("push_lat_range", 32'(push_lat >= 1 && push_lat < HB - 2), 32'd1);

        send_frame(8'h05, 0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0, 0);
        checkpoint("break");

        send_frame(8'hE0, 0, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0, 0);
        send_frame(8'h75, 0, 0, 0, 0);
        checkpoint("ext_break");

        send_frame(8'hF0, 1, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0, 0);
        checkpoint("parity");

        send_frame(8'hE0, 0, 0, 0, 0);
        send_partial(3);
        wait_cyc(500);
        exp_ferr++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        checkpoint("timeout");
        send_frame(8'h1C, 0, 0, 0, 0);
        send_frame(8'h2C, 0, 0, 1, 0);
        send_bad_start();
        send_frame(8'h33, 0, 1, 0, 0);
        checkpoint("glitch_frame");

        code_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) send_frame(8'(i), 0, 0, 0, 0);
        chk("full_valid", 32'(code_valid), 32'd1);
        checkpoint("overflow");
        send_frame(8'h0A, 0, 0, 0, 1);
        checkpoint("full_pushpop");
        code_ready = 1'b1;
        wait_cyc(2 * DEPTH);
        chk("drain_model", 32'(mq.size()), 32'd0);
        chk("drain_valid", 32'(code_valid), 32'd0);

        code_ready = 1'b0;
        send_frame(8'h11, 0, 0, 0, 0);
        send_frame(8'h22, 0, 0, 0, 0);
        chk("pre_rst_valid", 32'(code_valid), 32'd1);
        send_partial(4);
        reset = 1'b0;
        wait_cyc(3);
        chk("mid_rst_valid", 32'(code_valid), 32'd0);
        chk("mid_rst_data",  32'({code_ext, code_brk, code_data}), 32'd0);
        chk("mid_rst_led",   32'(led), 32'd0);
        reset = 1'b1;
        mq.delete();
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        exp_led = 8'h00;
        wait_cyc(GAP);
        code_ready = 1'b1;
        send_frame(8'h1C, 0, 0, 0, 0);
        checkpoint("after_rst");

        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) send_bad_start();
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                       $urandom_range(0, 4) == 0, 1'b0);
        end
        checkpoint("random");
        chk("random_drained", 32'(mq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hid_rx_fifo.md
Name: hid_rx_fifo

Overview:
- Parametrised next-generation PS/2 (HID) keyboard receiver.
- Synchronises and glitch-filters hid_clk/hid_dat, deframes 11-bit frames, and checks parity of configurable polarity.
- Folds E0/F0 prefixes into flags on the following code, and buffers decoded codes in a valid/ready FIFO.
- Sits between the board PS/2 pins and the consumer logic; also drives the 8 board LEDs with the last make code.

Parameters:
- CLK_FREQ_HZ, 100000000, dspclk frequency; used for the timeout.
- FILT_LEN, 8, dspclk cycles a synchronised hid_clk level must hold before the filtered clock follows; range 1..255.
- TIMEOUT_US, 2000, maximum gap between falling edges inside a frame before abort.
- FIFO_DEPTH, 8, number of entries; power of two, at least 2.
- ODD_PARITY, 1, 1 = odd parity (PS/2 standard), 0 = even.

Ports:
- dspclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- hid_clk  in  1  PS/2 clock, asynchronous.
- hid_dat  in  1  PS/2 data, asynchronous.
- code_valid  out  1  FIFO non-empty.
- code_ready  in  1  consumer pop; an entry is popped when code_valid && code_ready.
- code_data  out  8  head scan code.
- code_brk  out  1  head entry was preceded by F0.
- code_ext  out  1  head entry was preceded by E0.
- pari_err  out  1  one-cycle pulse on parity error.
- frame_err  out  1  one-cycle pulse on bad start bit, bad stop bit or timeout.
- overflow  out  1  one-cycle pulse when a push is dropped because the FIFO is full.
- led  out  8  last accepted make code (brk=0).

Behaviour:
- Reset (reset=0 at a dspclk edge): FSM=IDLE; FIFO empty; prefix flags cleared; code_valid=0; code_data/code_brk/code_ext=0; all pulse outputs 0; led=8'h00. Reset mid-frame discards the partial frame.
- Synchronisation: hid_clk and hid_dat each pass through a 2-flop synchroniser. The filtered clock changes only after the synchronised level has been stable for FILT_LEN consecutive cycles.
- Sampling: data is sampled on a filtered-clock falling edge, from synchronised hid_dat in the same cycle. Pulses on hid_clk shorter than FILT_LEN cycles are ignored.
- FSM transitions:
  - IDLE: on an edge, dat=0 -> DATA (bit count 0). dat=1 -> frame_err pulse, stay in IDLE.
  - DATA: shift LSB-first; after the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: on an edge -> IDLE. dat=0 -> frame_err and the byte is discarded. Otherwise parity is checked: XOR of the 8 data bits and the parity bit must equal ODD_PARITY.
- Timeout: in any non-IDLE state, a counter counts from each edge. Reaching CLK_FREQ_HZ/1000000*TIMEOUT_US cycles -> IDLE, frame_err pulse, prefix flags cleared.
- Parity error: pari_err pulse, byte discarded, prefix flags cleared.
- Good byte decode (registered one cycle after the stop edge):
  - 8'hE0 sets ext.
  - 8'hF0 sets brk.
  - Any other byte pushes {ext, brk, byte}, then both flags clear.
  - A repeated prefix keeps its flag set.
- FIFO behaviour:
  - Push when full: entry dropped, overflow pulse, flags still clear.
  - Push and pop in the same cycle: always accepted, including when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - code_valid rises the cycle after the push. code_data/code_brk/code_ext show the head; they are stable while code_valid && !code_ready.
- led updates on a push with brk=0, in the same cycle as the push, even if the push is dropped for overflow.
- Simultaneous events: at most one push per frame. Pulses never overlap, since each frame produces at most one error.

Decomposition:
- Package hid_pkg holds:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - PREFIX_EXT=8'hE0 and PREFIX_BRK=8'hF0.
  - FIFO entry width constant (10).
- One sub-module, hid_sync_filter: synchronisers, FILT_LEN glitch filter, falling-edge strobe. It outputs fall_stb and dat_sync.
- FSM, decoder and FIFO stay in the top module.

Test Plan:
- Make code: one frame 0x1C, parity 0, bits 80 us apart, code_ready=1 -> one pop with code_data=8'h1C, brk=0, ext=0; led=8'h1C; no error pulses.
- Break sequence: F0 (parity 1) then 1C (parity 0) -> exactly one entry, 1C with brk=1; led stays at the previous value.
- Extended break sequence: E0 (parity 0), F0, 75 -> one entry, 8'h75 with ext=1, brk=1.
- Parity error: F0 sent with parity 0 -> pari_err pulses once, no entry; the following 1C arrives with brk=0.
- Timeout and glitches: start bit plus 3 data bits, then hid_clk held high for 2.5 ms -> one frame_err pulse, FSM back in IDLE, and the next good frame decodes. A 3-cycle hid_clk glitch during a frame is ignored.
- Overflow: code_ready=0, FIFO_DEPTH+1 make codes 01..09 -> code_valid=1 and overflow pulses once on the 9th code. Entries pop in order 01..08. A push on the same cycle as a pop while full is accepted. Asserting reset mid-frame empties the FIFO and sets led=0.
